// File: rtl/control_unit.sv
// Hardwired control sequencer: walks fetch (T0..T2) and per-class execute steps (T3..T7)
// and decodes every datapath strobe from the current step and the IR opcode.
module control_unit #(
    parameter int unsigned          OP_W    = 5,
    parameter logic [OP_W-1:0]      ALU_INC = 5'b11111,
    parameter logic [OP_W-1:0]      ALU_ADD = 5'b00011
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     ir,
    input  logic            con,
    input  logic            stop,
    output logic            run,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            Cout,
    output logic            PCout,
    output logic            PCin,
    output logic            IRin,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Yin,
    output logic            Zin,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            HIin,
    output logic            HIout,
    output logic            LOin,
    output logic            LOout,
    output logic            CONin,
    output logic            OutportIn,
    output logic            InPortOut,
    output logic            Read,
    output logic            Write,
    output logic [OP_W-1:0] OpCode
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    state_e          state_q, state_d;
    logic [OP_W-1:0] opc;
    logic [OP_W-1:0] imm_op;
    logic is_alu, is_imm, is_ldi, is_ld, is_st, is_mem, is_muldiv, is_neg, is_br;
    logic is_jr, is_in, is_out, is_mfhi, is_mflo, is_halt, is_short;
    logic final_step;

    assign opc       = ir[31:27];
    assign is_alu    = (opc >= OP_ADD) && (opc <= OP_OR);
    assign is_imm    = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI);
    assign is_ldi    = (opc == OP_LDI);
    assign is_ld     = (opc == OP_LD);
    assign is_st     = (opc == OP_ST);
    assign is_mem    = is_ld || is_ldi || is_st;
    assign is_muldiv = (opc == OP_MUL) || (opc == OP_DIV);
    assign is_neg    = (opc == OP_NEG) || (opc == OP_NOT);
    assign is_br     = (opc == OP_BR);
    assign is_jr     = (opc == OP_JR);
    assign is_in     = (opc == OP_IN);
    assign is_out    = (opc == OP_OUT);
    assign is_mfhi   = (opc == OP_MFHI);
    assign is_mflo   = (opc == OP_MFLO);
    assign is_halt   = (opc == OP_HALT);
    // Everything without a multi-step sequence (nop and unassigned opcodes included) ends at T3
    assign is_short  = !(is_alu || is_imm || is_mem || is_muldiv || is_neg || is_br || is_halt);

    always_comb begin
        imm_op = OP_ADD;
        if (opc == OP_ANDI) imm_op = OP_AND;
        else if (opc == OP_ORI) imm_op = OP_OR;
    end

    always_comb begin
        final_step = 1'b0;
        case (state_q)
            S_T3:    final_step = is_short;
            S_T4:    final_step = is_neg;
            S_T5:    final_step = is_alu || is_imm || is_ldi;
            S_T6:    final_step = is_muldiv || is_br;
            S_T7:    final_step = 1'b1;
            default: final_step = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_HALT:  state_d = S_HALT;
            default: begin
                if (state_q == S_T3 && is_halt) state_d = S_HALT;
                else if (final_step)            state_d = stop ? S_HALT : S_T0;
                else begin
                    case (state_q)
                        S_T3:    state_d = S_T4;
                        S_T4:    state_d = S_T5;
                        S_T5:    state_d = S_T6;
                        default: state_d = S_T7;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_RESET;
        else      state_q <= state_d;
    end

    always_comb begin
        run = (state_q != S_RESET) && (state_q != S_HALT);
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IRin, MARin, MDRin, MDRout} = '0;
        {Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, CONin, OutportIn} = '0;
        {InPortOut, Read, Write} = '0;
        OpCode = '0;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; OpCode = ALU_INC; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_alu || is_imm)  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (is_mem)       begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                else if (is_muldiv)    begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (is_neg)       begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; OpCode = opc; end
                else if (is_br)        begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                else if (is_jr)        begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                else if (is_in)        begin InPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_out)       begin Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1; end
                else if (is_mfhi)      begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_mflo)      begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            S_T4: begin
                if (is_alu)            begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; OpCode = opc; end
                else if (is_imm)       begin Cout = 1'b1; Zin = 1'b1; OpCode = imm_op; end
                else if (is_mem)       begin Cout = 1'b1; Zin = 1'b1; OpCode = ALU_ADD; end
                else if (is_muldiv)    begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; OpCode = opc; end
                else if (is_neg)       begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_br)        begin PCout = 1'b1; Yin = 1'b1; end
            end
            S_T5: begin
                if (is_alu || is_imm || is_ldi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_ld || is_st)        begin Zlowout = 1'b1; MARin = 1'b1; end
                else if (is_muldiv)             begin Zlowout = 1'b1; LOin = 1'b1; end
                else if (is_br)                 begin Cout = 1'b1; Zin = 1'b1; OpCode = ALU_ADD; end
            end
            S_T6: begin
                if (is_ld)             begin Read = 1'b1; MDRin = 1'b1; end
                else if (is_st)        begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                else if (is_muldiv)    begin Zhighout = 1'b1; HIin = 1'b1; end
                else if (is_br && con) begin PCin = 1'b1; Zlowout = 1'b1; end
            end
            S_T7: begin
                if (is_ld)             begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_st)        Write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
